// File: rtl/dac_pkg.sv
// Shared types and constants for the MCP4812 update scheduler.
// Command word layout: {ch, 0, ga_n, shdn_n, code[9:0], 00}.
package dac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_GAP
  } state_t;

  localparam int CMD_CH    = 15;
  localparam int CMD_GA    = 13;
  localparam int CMD_SHDN  = 12;
  localparam int CMD_D_MSB = 11;
  localparam int CMD_D_LSB = 2;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  function automatic logic [15:0] build_cmd(input logic       ch,
                                            input logic       ga_n,
                                            input logic       shdn_n,
                                            input logic [9:0] code);
    logic [15:0] w;
    w                       = '0;
    w[CMD_CH]               = ch;
    w[CMD_GA]               = ga_n;
    w[CMD_SHDN]             = shdn_n;
    w[CMD_D_MSB:CMD_D_LSB]  = code;
    return w;
  endfunction

endpackage

// File: rtl/dac_update_scheduler_if.sv
// Handshake between the scheduler (master) and the MCP4812 SPI driver (slave).
interface dac_update_scheduler_if;
  logic [15:0] dac_data;
  logic        dac_data_valid;
  logic        dac_busy;

  modport master (output dac_data, output dac_data_valid, input dac_busy);
  modport slave  (input dac_data, input dac_data_valid, output dac_busy);
endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the requester not served last wins.
module rr_arb2
  import dac_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_q == CH_B) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (advance && (req != 2'b00)) last_d = gnt[CH_B] ? CH_B : CH_A;
  end

  // Reset to B so that channel A wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) last_q <= CH_B;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/dac_update_scheduler.sv
// Front end for the dual-channel MCP4812 driver: capture, coalesce, arbitrate, issue, watchdog.
// state   | meaning
// IDLE    | waiting for a pending channel and a free driver
// ISSUE   | word latched; valid pulses next cycle, watchdog loaded
// WAIT_HI | waiting for the driver to raise busy
// WAIT_LO | waiting for the driver to drop busy
// GAP     | enforced valid-low spacing before the next grant
module dac_update_scheduler
  import dac_pkg::*;
#(
  parameter int GAP_CYCLES  = 2,
  parameter int WDOG_CYCLES = 1023
)
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cha_wr,
  input  logic [9:0]                    cha_data,
  input  logic                          chb_wr,
  input  logic [9:0]                    chb_data,
  input  logic [1:0]                    cfg_ga_n,
  input  logic [1:0]                    cfg_shdn_n,
  input  logic                          err_clr,
  dac_update_scheduler_if.master        dac,
  output logic [1:0]                    pending,
  output logic                          idle,
  output logic [1:0]                    overwrite_err,
  output logic                          timeout_err
);

  localparam logic [15:0] WDOG_LOAD = 16'(WDOG_CYCLES);
  localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] tmr_q, tmr_d;
  logic [9:0]  hold_a_q, hold_a_d;
  logic [9:0]  hold_b_q, hold_b_d;
  logic [1:0]  pending_q, pending_d;
  logic [1:0]  ovf_q, ovf_d;
  logic        tmo_q, tmo_d;
  logic [15:0] data_q, data_d;
  logic        valid_q, valid_d;

  logic [1:0]  gnt;
  logic        grant_en;
  logic        gnt_a, gnt_b;
  logic        waiting;
  logic        tmo_evt;

  assign grant_en = (state_q == ST_IDLE) && !dac.dac_busy && (pending_q != 2'b00);
  assign gnt_a    = grant_en & gnt[CH_A];
  assign gnt_b    = grant_en & gnt[CH_B];
  assign waiting  = (state_q == ST_WAIT_HI) || (state_q == ST_WAIT_LO);
  assign tmo_evt  = waiting && (tmr_q == 16'd0);

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (pending_q),
    .advance (grant_en),
    .gnt     (gnt)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (grant_en) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (tmo_evt)           state_d = ST_GAP;
        else if (dac.dac_busy) state_d = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (tmo_evt || !dac.dac_busy) state_d = ST_GAP;
      end
      ST_GAP:     if (tmr_q == 16'd0) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // A write landing in the grant cycle re-arms pending without counting as an overwrite.
  always_comb begin
    pending_d[CH_A] = cha_wr | (pending_q[CH_A] & ~gnt_a);
    pending_d[CH_B] = chb_wr | (pending_q[CH_B] & ~gnt_b);
    hold_a_d        = cha_wr ? cha_data : hold_a_q;
    hold_b_d        = chb_wr ? chb_data : hold_b_q;
    ovf_d[CH_A]     = (ovf_q[CH_A] & ~err_clr) | (cha_wr & pending_q[CH_A] & ~gnt_a);
    ovf_d[CH_B]     = (ovf_q[CH_B] & ~err_clr) | (chb_wr & pending_q[CH_B] & ~gnt_b);
    tmo_d           = (tmo_q & ~err_clr) | tmo_evt;
    valid_d         = (state_q == ST_ISSUE);

    data_d = data_q;
    if (grant_en) begin
      data_d = build_cmd(gnt[CH_B], cfg_ga_n[gnt[CH_B]], cfg_shdn_n[gnt[CH_B]],
                         gnt[CH_B] ? hold_b_q : hold_a_q);
    end

    // One down-counter serves as watchdog (from ISSUE) and as gap timer.
    tmr_d = tmr_q;
    if (state_q == ST_ISSUE)
      tmr_d = WDOG_LOAD;
    else if ((state_d == ST_GAP) && (state_q != ST_GAP))
      tmr_d = GAP_LOAD;
    else if ((waiting || (state_q == ST_GAP)) && (tmr_q != 16'd0))
      tmr_d = tmr_q - 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmr_q     <= '0;
      hold_a_q  <= '0;
      hold_b_q  <= '0;
      pending_q <= '0;
      ovf_q     <= '0;
      tmo_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      tmr_q     <= tmr_d;
      hold_a_q  <= hold_a_d;
      hold_b_q  <= hold_b_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      tmo_q     <= tmo_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  assign dac.dac_data       = data_q;
  assign dac.dac_data_valid = valid_q;
  assign pending            = pending_q;
  assign overwrite_err      = ovf_q;
  assign timeout_err        = tmo_q;
  assign idle               = (state_q == ST_IDLE) && (pending_q == 2'b00) && !dac.dac_busy;

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Self-checking bench: directed vectors and corner sequences, then random traffic vs a timing model.
module tb_dac_update_scheduler;

  localparam int GAP = 2;
  localparam int W   = 24;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cha_wr = 1'b0, chb_wr = 1'b0, err_clr = 1'b0;
  logic [9:0] cha_data = '0, chb_data = '0;
  logic [1:0] cfg_ga_n = 2'b11, cfg_shdn_n = 2'b11;
  logic [1:0] pending, overwrite_err;
  logic       idle, timeout_err;

  dac_update_scheduler_if dif();

  dac_update_scheduler #(.GAP_CYCLES(GAP), .WDOG_CYCLES(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .cha_wr        (cha_wr),
    .cha_data      (cha_data),
    .chb_wr        (chb_wr),
    .chb_data      (chb_data),
    .cfg_ga_n      (cfg_ga_n),
    .cfg_shdn_n    (cfg_shdn_n),
    .err_clr       (err_clr),
    .dac           (dif),
    .pending       (pending),
    .idle          (idle),
    .overwrite_err (overwrite_err),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  int          nchk = 0;
  int          nerr = 0;
  int          cyc  = 0;
  bit          auto_busy = 1'b1;
  int          rsp = 0;
  bit          v_now;
  logic [15:0] w_now;

  typedef struct {
    bit          ch;
    logic [9:0]  code;
    logic        ga;
    logic        sh;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one cycle; strobes last exactly one edge; optional busy responder (busy 2 cycles after valid).
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    cha_wr  = 1'b0;
    chb_wr  = 1'b0;
    err_clr = 1'b0;
    if (auto_busy) begin
      if (rsp > 0) begin dif.dac_busy = 1'b1; rsp--; end
      else dif.dac_busy = 1'b0;
    end
    v_now = dif.dac_data_valid;
    w_now = dif.dac_data;
    if (auto_busy && v_now) rsp = 2;
  endtask

  task automatic wait_valid(input string name, input int maxc, output int waited);
    bit found = 1'b0;
    waited = 0;
    while (!found && waited < maxc) begin
      tick();
      waited++;
      found = v_now;
    end
    if (!found) begin
      nchk++; nerr++;
      $display("FAIL %s: no dac_data_valid within %0d cycles", name, maxc);
    end
  endtask

  task automatic wait_idle(input string name, input int maxc, output int waited);
    bit found = 1'b0;
    waited = 0;
    while (!found && waited < maxc) begin
      tick();
      waited++;
      found = (idle === 1'b1);
    end
    if (!found) begin
      nchk++; nerr++;
      $display("FAIL %s: idle not reached within %0d cycles", name, maxc);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", nerr);
    $fatal(1);
  end

  initial begin
    vec_t        tbl [6];
    int          n, t0, cnt;
    bit          chs [6];
    int          nw;
    // reference model state
    bit [1:0]    m_pend, m_ovf, old, set;
    bit          m_tmo, m_last, busy_c;
    bit [9:0]    m_val [2];
    int          m_word, exp_v, bs, be, free_at, tmo_at, g;

    tbl[0] = '{1'b1, 10'h001, 1'b1, 1'b1, 16'hB004};
    tbl[1] = '{1'b0, 10'h3FF, 1'b1, 1'b1, 16'h3FFC};
    tbl[2] = '{1'b1, 10'h3FF, 1'b0, 1'b0, 16'h8FFC};
    tbl[3] = '{1'b0, 10'h000, 1'b0, 1'b1, 16'h1000};
    tbl[4] = '{1'b0, 10'h2AA, 1'b0, 1'b0, 16'h0AA8};
    tbl[5] = '{1'b1, 10'h200, 1'b1, 1'b0, 16'hA800};

    dif.dac_busy = 1'b0;

    // reset values
    reset = 1'b1;
    repeat (3) tick();
    check("rst_valid", dif.dac_data_valid, 1'b0);
    check("rst_data", dif.dac_data, 16'h0000);
    check("rst_pending", pending, 2'b00);
    check("rst_ovf", overwrite_err, 2'b00);
    check("rst_tmo", timeout_err, 1'b0);
    check("rst_idle", idle, 1'b1);
    reset = 1'b0;

    // single write and its latency
    cha_wr = 1'b1; cha_data = 10'h155; cfg_ga_n = 2'b11; cfg_shdn_n = 2'b11;
    tick();
    check("single_pending_set", pending, 2'b01);
    check("single_valid_n", dif.dac_data_valid, 1'b0);
    tick();
    check("single_valid_n1", dif.dac_data_valid, 1'b0);
    check("single_pending_clr", pending, 2'b00);
    tick();
    check("single_valid_n2", dif.dac_data_valid, 1'b1);
    check("single_word", dif.dac_data, 16'h3554);
    wait_idle("single_idle", 30, n);
    check("single_idle_delay", n, 3 + GAP + 1);

    // command word vectors
    for (int i = 0; i < 6; i++) begin
      cfg_ga_n   = {2{tbl[i].ga}};
      cfg_shdn_n = {2{tbl[i].sh}};
      if (tbl[i].ch) begin chb_wr = 1'b1; chb_data = tbl[i].code; end
      else begin cha_wr = 1'b1; cha_data = tbl[i].code; end
      wait_valid("vec_valid", 10, n);
      check("vec_latency", n, 3);
      check("vec_word", w_now, tbl[i].exp);
      wait_idle("vec_idle", 30, n);
    end

    // simultaneous writes: A first, then B
    cfg_ga_n = 2'b11; cfg_shdn_n = 2'b11;
    cha_wr = 1'b1; cha_data = 10'h3FF;
    chb_wr = 1'b1; chb_data = 10'h001;
    wait_valid("simul_first", 10, n);
    check("simul_first_word", w_now, 16'h3FFC);
    t0 = cyc;
    wait_valid("simul_second", 30, n);
    check("simul_second_word", w_now, 16'hB004);
    check("simul_spacing", cyc - t0, 3 + GAP + 3);
    wait_idle("simul_idle", 30, n);

    // coalescing while A is in flight
    cha_wr = 1'b1; cha_data = 10'h100;
    wait_valid("coal_a", 10, n);
    chb_wr = 1'b1; chb_data = 10'h010;
    tick();
    chb_wr = 1'b1; chb_data = 10'h020;
    tick();
    check("coal_ovf", overwrite_err, 2'b10);
    check("coal_pending", pending, 2'b10);
    wait_valid("coal_b", 30, n);
    check("coal_b_word", w_now, 16'hB080);
    wait_idle("coal_idle", 30, n);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (v_now) cnt++; end
    check("coal_single_send", cnt, 0);
    err_clr = 1'b1;
    tick();
    check("coal_err_clr", overwrite_err, 2'b00);

    // write in the grant cycle wins without an overwrite error
    chb_wr = 1'b1; chb_data = 10'h030;
    tick();
    chb_wr = 1'b1; chb_data = 10'h040;
    wait_valid("gc_first", 10, n);
    check("gc_first_word", w_now, 16'hB0C0);
    check("gc_pending_kept", pending, 2'b10);
    check("gc_no_ovf", overwrite_err, 2'b00);
    wait_valid("gc_second", 30, n);
    check("gc_second_word", w_now, 16'hB100);
    wait_idle("gc_idle", 30, n);

    // fairness under continuous rewrites
    nw = 0; n = 0;
    while (nw < 6 && n < 200) begin
      cha_wr = 1'b1; cha_data = 10'(n);
      chb_wr = 1'b1; chb_data = 10'(n + 7);
      tick();
      n++;
      if (v_now) begin chs[nw] = w_now[15]; nw++; end
    end
    if (nw < 6) begin
      nchk++; nerr++;
      $display("FAIL fair_words: only %0d words in %0d cycles", nw, n);
    end
    for (int i = 1; i < nw; i++) check("fair_alternate", chs[i], !chs[i-1]);
    wait_idle("fair_idle", 60, n);
    err_clr = 1'b1;
    tick();

    // watchdog: driver never raises busy
    auto_busy = 1'b0; dif.dac_busy = 1'b0;
    cha_wr = 1'b1; cha_data = 10'h155;
    wait_valid("wd_valid", 10, n);
    chb_wr = 1'b1; chb_data = 10'h001;
    n = 0;
    while (timeout_err !== 1'b1 && n < 3 * W) begin tick(); n++; end
    check("wd_delay", n, W + 1);
    auto_busy = 1'b1; rsp = 0;
    wait_valid("wd_next", 20, n);
    check("wd_next_delay", n, GAP + 2);
    check("wd_next_word", w_now, 16'hB004);
    check("wd_sticky", timeout_err, 1'b1);
    wait_idle("wd_idle", 30, n);
    err_clr = 1'b1;
    tick();
    check("wd_clr", timeout_err, 1'b0);

    // reset in WAIT_LO with B pending
    auto_busy = 1'b0; dif.dac_busy = 1'b0;
    cha_wr = 1'b1; cha_data = 10'h155;
    wait_valid("rm_valid", 10, n);
    dif.dac_busy = 1'b1;
    tick();
    tick();
    chb_wr = 1'b1; chb_data = 10'h001;
    tick();
    chb_wr = 1'b1; chb_data = 10'h002;
    tick();
    check("rm_pre_pending", pending, 2'b10);
    check("rm_pre_ovf", overwrite_err, 2'b10);
    reset = 1'b1; dif.dac_busy = 1'b0;
    tick();
    check("rm_valid", dif.dac_data_valid, 1'b0);
    check("rm_pending", pending, 2'b00);
    check("rm_ovf", overwrite_err, 2'b00);
    check("rm_tmo", timeout_err, 1'b0);
    check("rm_data", dif.dac_data, 16'h0000);
    check("rm_idle", idle, 1'b1);

    // random traffic against a transaction-timing model
    m_pend = 0; m_ovf = 0; m_tmo = 0; m_last = 1'b1;
    m_val[0] = 0; m_val[1] = 0;
    m_word = 0; exp_v = -1; bs = 0; be = 0; free_at = 0; tmo_at = -1;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) tick();
      reset      = 1'b0;
      cha_wr     = ($urandom_range(0, 3) == 0);
      cha_data   = 10'($urandom_range(0, 1023));
      chb_wr     = ($urandom_range(0, 3) == 0);
      chb_data   = 10'($urandom_range(0, 1023));
      err_clr    = ($urandom_range(0, 15) == 0);
      cfg_ga_n   = 2'($urandom_range(0, 3));
      cfg_shdn_n = 2'($urandom_range(0, 3));
      busy_c     = (c >= bs) && (c < be);
      dif.dac_busy = busy_c;
      #1;
      check("rnd_pending", pending, m_pend);
      check("rnd_ovf", overwrite_err, m_ovf);
      check("rnd_tmo", timeout_err, m_tmo);
      check("rnd_valid", dif.dac_data_valid, (c == exp_v));
      if (c == exp_v) check("rnd_word", dif.dac_data, m_word);
      check("rnd_idle", idle, (c >= free_at) && (m_pend == 0) && !busy_c);

      old = m_pend; g = -1; set = 0;
      if (c >= free_at && m_pend != 0 && !busy_c) begin
        if (m_pend == 2'b11) g = m_last ? 0 : 1;
        else                 g = m_pend[1] ? 1 : 0;
        m_word = g * 32768 + int'(cfg_ga_n[g]) * 8192 + int'(cfg_shdn_n[g]) * 4096
                 + int'(m_val[g]) * 4;
        m_pend[g] = 1'b0;
        m_last    = (g == 1);
        exp_v     = c + 2;
        if ($urandom_range(0, 7) == 0) begin
          bs = 0; be = 0;
          tmo_at  = c + 3 + W;
          free_at = c + 3 + W + GAP;
        end else begin
          bs = c + 2 + $urandom_range(1, 3);
          be = bs + $urandom_range(1, 4);
          tmo_at  = -1;
          free_at = be + GAP + 1;
        end
      end
      if (cha_wr) begin
        if (old[0] && g != 0) set[0] = 1'b1;
        m_val[0] = cha_data; m_pend[0] = 1'b1;
      end
      if (chb_wr) begin
        if (old[1] && g != 1) set[1] = 1'b1;
        m_val[1] = chb_data; m_pend[1] = 1'b1;
      end
      m_ovf = (m_ovf & ~{2{err_clr}}) | set;
      m_tmo = (m_tmo & !err_clr) | (c + 1 == tmo_at);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/dac_update_scheduler.md
Name: dac_update_scheduler

Overview:
- Front-end controller for the dual-channel MCP4812 SPI DAC driver.
- Accepts independent update requests for channel A and channel B.
- Coalesces repeated writes, arbitrates round-robin, builds the 16-bit MCP4812 command word, and sequences the driver's data/data_valid/busy handshake with a watchdog.
- Sits between the acquisition/control logic and the DAC driver; it is the only master of the driver.

Parameters:
- GAP_CYCLES, 2, idle cycles with dac_data_valid low between words (min 1; guarantees a rising edge for the driver).
- WDOG_CYCLES, 1023, max cycles from ISSUE to busy falling before a timeout is declared (16-bit counter).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cha_wr  in  1  one-cycle write strobe, channel A
- cha_data  in  10  channel A code
- chb_wr  in  1  one-cycle write strobe, channel B
- chb_data  in  10  channel B code
- cfg_ga_n  in  2  per-channel GA_n bit ([0]=A, [1]=B; 1 = 1x gain); sampled at grant
- cfg_shdn_n  in  2  per-channel SHDN_n bit ([0]=A, [1]=B); sampled at grant
- err_clr  in  1  clears the sticky error flags
- dac_data  out  16  command word to the driver
- dac_data_valid  out  1  registered; high exactly one cycle per word
- dac_busy  in  1  driver busy
- pending  out  2  per-channel update waiting
- idle  out  1  FSM in IDLE, nothing pending, dac_busy low
- overwrite_err  out  2  sticky; a write replaced a not-yet-sent value
- timeout_err  out  1  sticky; watchdog expired

Behaviour:
- Reset: state IDLE; dac_data=0; dac_data_valid=0; pending=0; overwrite_err=0; timeout_err=0; last_served=B (so A wins first tie).
- Write capture:
  - chX_wr loads the holding register and sets pending[X] next cycle.
  - If pending[X] is already set, the new value replaces the old one and overwrite_err[X] is set.
  - cha_wr and chb_wr in the same cycle are both captured.
- Command word: {ch(0=A,1=B), 1'b0, ga_n, shdn_n, code[9:0], 2'b00}.
- FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO, GAP.
  - IDLE: when dac_busy=0 and pending≠0, grant a channel.
    - Single pending channel: that channel is granted.
    - Both pending: the channel ≠ last_served is granted.
    - On grant: latch dac_data, clear pending for the granted channel, update last_served, go to ISSUE.
    - A write to the granted channel in the grant cycle wins: pending stays set with the new data, and the latched word keeps the old value. No overwrite_err is raised in this case.
  - ISSUE: dac_data_valid=1 for exactly one cycle; watchdog loads 0; go to WAIT_HI.
  - WAIT_HI: wait for dac_busy=1, then go to WAIT_LO.
  - WAIT_LO: wait for dac_busy=0, then go to GAP.
  - Watchdog: counts in WAIT_HI and WAIT_LO. When the count reaches WDOG_CYCLES, set timeout_err and go to GAP; the word counts as sent.
  - GAP: count GAP_CYCLES, then go to IDLE.
- Timing:
  - Latency from a write sampled at edge N (idle, nothing pending) to dac_data_valid high: cycle after edge N+2.
  - dac_data is stable from ISSUE until the next grant.
- err_clr clears both sticky flags. If a set event occurs in the same cycle as err_clr, the set wins.
- Reset mid-transaction: immediate return to reset values and pending writes are lost. The driver shares the same reset.

Decomposition:
- Package dac_pkg holds:
  - FSM state enum.
  - Command bit positions: CMD_CH=15, CMD_GA=13, CMD_SHDN=12, CMD_D_MSB=11, CMD_D_LSB=2.
  - Channel constants CH_A=0, CH_B=1.
- One natural sub-module, rr_arb2: a 2-requester round-robin arbiter with last_served state.
- The FSM, holding registers and watchdog stay in the top module.

Test Plan:
- Single write: cha_wr with 0x155, ga_n=1, shdn_n=1 → one dac_data_valid pulse; dac_data=0x3554; pending returns to 0; idle high after busy falls plus GAP.
- Simultaneous: cha_wr 0x3FF and chb_wr 0x001 in the same cycle → A sent first (0x3FFC | 0x3000 = 0x3FFC), then B (0xB004); two pulses at least GAP_CYCLES+1 apart.
- Coalesce: while A is in flight, chb_wr 0x010 then chb_wr 0x020 → only B=0x020 is sent; overwrite_err=2'b10; err_clr returns it to 0.
- Fairness: A and B rewritten continuously → grants alternate A,B,A,B; neither channel is starved.
- Watchdog: dac_busy held 0 after ISSUE → timeout_err set WDOG_CYCLES cycles later; FSM reaches IDLE and the next pending word is issued.
- Reset mid-WAIT_LO with B pending → the cycle after reset: dac_data_valid=0, pending=0, both error flags 0, state IDLE.
